// File: rtl/inst_block_buffer_pkg.sv
// Shared types for the instruction block ring buffer: FSM state encoding
// used by both the write-side and read-side controllers.
package inst_block_buffer_pkg;

  localparam int FSM_STATE_W = 2;

  typedef enum logic [FSM_STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/inst_bank_ram.sv
// One lane of instruction storage: simple dual-port RAM, one write port,
// one read port with a single registered read stage.
module inst_bank_ram
  import inst_block_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/inst_block_buffer.sv
// Ring of NUM_BUFS instruction blocks between an AXI-fed writer and a consumer.
// Optional read bounds checking is enabled with `define IMEM_RD_BOUNDS_CHECK_EN.
module inst_block_buffer
  import inst_block_buffer_pkg::*;
#(
  parameter int NUM_INST_IN     = 2,
  parameter int INST_DATA_WIDTH = 32,
  parameter int INST_ADDR_WIDTH = 10,
  parameter int NUM_BUFS        = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  output logic                                   wr_start,
  input  logic                                   wr_data_valid,
  input  logic [NUM_INST_IN*INST_DATA_WIDTH-1:0] wr_data,
  input  logic                                   wr_done,
  input  logic                                   rd_req,
  input  logic [INST_ADDR_WIDTH-1:0]             rd_addr,
  output logic [INST_DATA_WIDTH-1:0]             rd_data,
  output logic                                   rd_valid,
  input  logic                                   rd_block_done,
  output logic                                   block_ready,
  output logic [$clog2(NUM_BUFS):0]              num_full
`ifdef IMEM_RD_BOUNDS_CHECK_EN
  , output logic                                 rd_oob_err
`endif
);

  localparam int LANE_W = $clog2(NUM_INST_IN);
  localparam int SEL_W  = (LANE_W == 0) ? 1 : LANE_W;
  localparam int BEAT_W = INST_ADDR_WIDTH - LANE_W;
  localparam int CNT_W  = BEAT_W + 1;
  localparam int PTR_W  = $clog2(NUM_BUFS);
  localparam int NF_W   = PTR_W + 1;
  localparam int RAM_AW = PTR_W + BEAT_W;
  localparam logic [CNT_W-1:0] BEAT_MAX = {1'b1, {BEAT_W{1'b0}}};

  fsm_state_t r_wr_state, w_wr_state_next;
  fsm_state_t r_rd_state, w_rd_state_next;

  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic              r_full [NUM_BUFS];
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_wr_start, r_rd_valid;
  logic [SEL_W-1:0]  r_lane_sel;
  logic [NF_W-1:0]   r_num_full;

  logic              w_wr_fire, w_rd_fire, w_wr_en, w_rd_accept, w_rd_zero;
  logic [BEAT_W-1:0] w_rd_beat;
  logic [SEL_W-1:0]  w_lane;
  logic [INST_DATA_WIDTH-1:0] w_lane_data [NUM_INST_IN];

  assign w_wr_fire   = (r_wr_state == ST_DONE);
  assign w_rd_fire   = (r_rd_state == ST_DONE);
  // Beats past the block depth are dropped; the counter parks at BEAT_MAX.
  assign w_wr_en     = (r_wr_state == ST_DATA) && wr_data_valid && (r_beat_cnt != BEAT_MAX);
  assign w_rd_accept = (r_rd_state == ST_DATA) && rd_req;
  assign w_rd_beat   = rd_addr[INST_ADDR_WIDTH-1:LANE_W];

  generate
    if (LANE_W > 0) begin : g_lane_sel
      assign w_lane = rd_addr[SEL_W-1:0];
    end else begin : g_lane_zero
      assign w_lane = '0;
    end
  endgenerate

  always_comb begin
    w_wr_state_next = r_wr_state;
    case (r_wr_state)
      ST_IDLE: if (start) w_wr_state_next = ST_WAIT;
      ST_WAIT: if (!r_full[r_wr_ptr]) w_wr_state_next = ST_DATA;
      ST_DATA: if (wr_done) w_wr_state_next = ST_DONE;
      ST_DONE: w_wr_state_next = ST_WAIT;
      default: w_wr_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    case (r_rd_state)
      ST_IDLE: if (start) w_rd_state_next = ST_WAIT;
      ST_WAIT: if (r_full[r_rd_ptr]) w_rd_state_next = ST_DATA;
      ST_DATA: if (rd_block_done) w_rd_state_next = ST_DONE;
      ST_DONE: w_rd_state_next = ST_WAIT;
      default: w_rd_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= ST_IDLE;
      r_rd_state <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_beat_cnt <= '0;
      r_wr_start <= 1'b0;
      r_rd_valid <= 1'b0;
      r_lane_sel <= '0;
      r_num_full <= '0;
    end else begin
      r_wr_state <= w_wr_state_next;
      r_rd_state <= w_rd_state_next;
      r_wr_start <= (r_wr_state == ST_WAIT) && (w_wr_state_next == ST_DATA);
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) r_lane_sel <= w_lane;
      if (w_wr_fire) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_beat_cnt <= '0;
      end else if (w_wr_en) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_fire, w_rd_fire})
        2'b10:   r_num_full <= r_num_full + NF_W'(1);
        2'b01:   r_num_full <= r_num_full - NF_W'(1);
        default: r_num_full <= r_num_full;
      endcase
    end
  end

  // Per-buffer flags let set and clear on different buffers land together.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUFS; gi++) begin : g_full
      always_ff @(posedge clk) begin
        if (reset)
          r_full[gi] <= 1'b0;
        else if (w_wr_fire && (r_wr_ptr == PTR_W'(gi)))
          r_full[gi] <= 1'b1;
        else if (w_rd_fire && (r_rd_ptr == PTR_W'(gi)))
          r_full[gi] <= 1'b0;
      end
    end

    for (gi = 0; gi < NUM_INST_IN; gi++) begin : g_lane
      inst_bank_ram #(
        .DATA_WIDTH (INST_DATA_WIDTH),
        .ADDR_WIDTH (RAM_AW)
      ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr ({r_wr_ptr, r_beat_cnt[BEAT_W-1:0]}),
        .i_wr_data (wr_data[gi*INST_DATA_WIDTH +: INST_DATA_WIDTH]),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr ({r_rd_ptr, w_rd_beat}),
        .o_rd_data (w_lane_data[gi])
      );
    end
  endgenerate

`ifdef IMEM_RD_BOUNDS_CHECK_EN
  logic [CNT_W-1:0] r_len [NUM_BUFS];
  logic             r_oob, r_oob_err, w_rd_oob;

  assign w_rd_oob = ({1'b0, w_rd_beat} >= r_len[r_rd_ptr]);

  generate
    for (gi = 0; gi < NUM_BUFS; gi++) begin : g_len
      always_ff @(posedge clk) begin
        if (reset)
          r_len[gi] <= '0;
        else if (w_wr_fire && (r_wr_ptr == PTR_W'(gi)))
          r_len[gi] <= r_beat_cnt;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_oob     <= 1'b0;
      r_oob_err <= 1'b0;
    end else begin
      r_oob <= w_rd_accept && w_rd_oob;
      if (w_rd_accept && w_rd_oob) r_oob_err <= 1'b1;
    end
  end

  assign rd_oob_err = r_oob_err;
  assign w_rd_zero  = r_oob;
`else
  assign w_rd_zero  = 1'b0;
`endif

  // Gating with rd_valid keeps rd_data at 0 after reset without resetting the RAM.
  assign rd_data     = (r_rd_valid && !w_rd_zero) ? w_lane_data[r_lane_sel] : '0;
  assign rd_valid    = r_rd_valid;
  assign wr_start    = r_wr_start;
  assign num_full    = r_num_full;
  assign block_ready = (r_rd_state == ST_DATA) && r_full[r_rd_ptr];

endmodule

// File: tb/tb_inst_block_buffer.sv
// Self-checking bench for inst_block_buffer: table-driven fill check, ring/wrap,
// simultaneous DONE, mid-block reset, overflow, and randomized block traffic.
`timescale 1ns/1ps
module tb_inst_block_buffer;

  localparam int NI    = 2;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int NB    = 4;
  localparam int BEATS = (1 << AW) / NI;

  logic              clk = 1'b0;
  logic              reset, start, wr_start, wr_data_valid, wr_done;
  logic              rd_req, rd_valid, rd_block_done, block_ready;
  logic [NI*DW-1:0]  wr_data;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic [$clog2(NB):0] num_full;
`ifdef IMEM_RD_BOUNDS_CHECK_EN
  logic              rd_oob_err;
`endif

  always #5 clk = ~clk;

  inst_block_buffer #(
    .NUM_INST_IN(NI), .INST_DATA_WIDTH(DW), .INST_ADDR_WIDTH(AW), .NUM_BUFS(NB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .wr_start(wr_start),
    .wr_data_valid(wr_data_valid), .wr_data(wr_data), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_block_done(rd_block_done), .block_ready(block_ready), .num_full(num_full)
`ifdef IMEM_RD_BOUNDS_CHECK_EN
    , .rd_oob_err(rd_oob_err)
`endif
  );

  typedef struct {
    int          tag;
    int          nbeats;
    logic [31:0] salt;
  } blk_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_start_cnt  = 0;
  int   wr_start_used = 0;
  blk_t exp_q[$];

  // wr_start is a single-cycle pulse; counting pulses lets the writer task
  // consume one even if it arrived while the bench was busy reading.
  always @(negedge clk) if (!reset && wr_start) wr_start_cnt++;

  function automatic logic [31:0] inst_val(input blk_t b, input int idx);
    return b.salt ^ (32'(b.tag) << 20) ^ 32'(idx);
  endfunction

  function automatic blk_t mk_blk(input int tag);
    blk_t b;
    b.tag    = tag;
    b.nbeats = $urandom_range(1, 8);
    b.salt   = $urandom;
    return b;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_wr_start();
    int budget = 0;
    while (wr_start_cnt <= wr_start_used && budget < 300) begin
      step();
      budget++;
    end
    chk("wr_start_arrives", 64'(wr_start_cnt > wr_start_used), 1);
    wr_start_used = wr_start_cnt;
  endtask

  task automatic write_block(input blk_t b, input bit with_rd_done);
    wait_wr_start();
    for (int k = 0; k < b.nbeats; k++) begin
      for (int l = 0; l < NI; l++) wr_data[l*DW +: DW] = inst_val(b, k*NI + l);
      wr_data_valid = 1'b1;
      step();
    end
    wr_data_valid = 1'b0;
    wr_done       = 1'b1;
    rd_block_done = with_rd_done;
    step();
    wr_done       = 1'b0;
    rd_block_done = 1'b0;
    if (with_rd_done) void'(exp_q.pop_front());
    if (b.nbeats > BEATS) b.nbeats = BEATS;
    exp_q.push_back(b);
    step();
    chk($sformatf("num_full_after_wr_tag%0d", b.tag), 64'(num_full), 64'(exp_q.size()));
    $display("[TB] write block tag=%0d beats=%0d num_full=%0d", b.tag, b.nbeats, num_full);
  endtask

  task automatic do_read(input int a, input logic [31:0] exp);
    rd_addr = AW'(a);
    rd_req  = 1'b1;
    step();
    rd_req  = 1'b0;
    chk($sformatf("rd_valid_a%0d", a), 64'(rd_valid), 1);
    chk($sformatf("rd_data_a%0d", a), 64'(rd_data), 64'(exp));
  endtask

  task automatic wait_ready();
    int budget = 0;
    while (!block_ready && budget < 300) begin
      step();
      budget++;
    end
    chk("block_ready", 64'(block_ready), 1);
  endtask

  task automatic finish_read();
    int tag = exp_q[0].tag;
    rd_block_done = 1'b1;
    step();
    rd_block_done = 1'b0;
    step();
    void'(exp_q.pop_front());
    chk($sformatf("num_full_after_rd_tag%0d", tag), 64'(num_full), 64'(exp_q.size()));
    $display("[TB] read block tag=%0d done num_full=%0d", tag, num_full);
  endtask

  task automatic read_block(input int nrd, input bit finish);
    blk_t b = exp_q[0];
    int   last = b.nbeats*NI - 1;
    int   a;
    wait_ready();
    for (int r = 0; r < nrd; r++) begin
      a = (r == 0) ? 0 : (r == 1) ? last : int'($urandom_range(0, last));
      do_read(a, inst_val(b, a));
    end
    if (finish) finish_read();
  endtask

  task automatic check_idle_outputs(input string tagname);
    chk({tagname, "_wr_start"}, 64'(wr_start), 0);
    chk({tagname, "_rd_valid"}, 64'(rd_valid), 0);
    chk({tagname, "_rd_data"}, 64'(rd_data), 0);
    chk({tagname, "_block_ready"}, 64'(block_ready), 0);
    chk({tagname, "_num_full"}, 64'(num_full), 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[16];
    blk_t b;
    int   tag;
    int   extra;

    for (int i = 0; i < 16; i++) begin
      vecs[i].addr = AW'(i);
      vecs[i].exp  = DW'(i);
    end

    reset = 1'b1; start = 1'b0; wr_data_valid = 1'b0; wr_done = 1'b0;
    wr_data = '0; rd_req = 1'b0; rd_addr = '0; rd_block_done = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check_idle_outputs("reset");

    // Stray strobes before start must be ignored.
    rd_req = 1'b1; wr_data_valid = 1'b1; wr_data = '1; rd_block_done = 1'b1;
    step();
    rd_req = 1'b0; wr_data_valid = 1'b0; rd_block_done = 1'b0;
    chk("rd_valid_outside_data", 64'(rd_valid), 0);
    step();

    start = 1'b1; step(); start = 1'b0;

    // Fill check: lane1 = 2k+1, lane0 = 2k.
    b.tag = 0; b.nbeats = 8; b.salt = 32'd0;
    write_block(b, 1'b0);
    wait_ready();
    for (int i = 0; i < 16; i++) do_read(int'(vecs[i].addr), vecs[i].exp);
    finish_read();

    // Ring-full check.
    for (int t = 1; t <= 4; t++) write_block(mk_blk(t), 1'b0);
    chk("ring_full_num_full", 64'(num_full), 4);
    repeat (30) step();
    chk("no_5th_wr_start", 64'(wr_start_cnt - wr_start_used), 0);

    // Stream through the ring so both pointers wrap several times.
    for (int j = 0; j < 6; j++) begin
      read_block(3, 1'b1);
      write_block(mk_blk(5 + j), 1'b0);
    end
    for (int j = 0; j < 3; j++) read_block(3, 1'b1);

    // Simultaneous write DONE and read DONE on different buffers.
    chk("pre_simul_num_full", 64'(num_full), 1);
    read_block(2, 1'b0);
    write_block(mk_blk(11), 1'b1);
    chk("post_simul_num_full", 64'(num_full), 1);
    write_block(mk_blk(12), 1'b0);
    write_block(mk_blk(13), 1'b0);
    write_block(mk_blk(14), 1'b0);
    chk("simul_refill_num_full", 64'(num_full), 4);
    for (int j = 0; j < 4; j++) read_block(3, 1'b1);

    // Reset asserted during write beat 3.
    wait_wr_start();
    b = mk_blk(15);
    for (int k = 0; k < 3; k++) begin
      for (int l = 0; l < NI; l++) wr_data[l*DW +: DW] = inst_val(b, k*NI + l);
      wr_data_valid = 1'b1;
      if (k == 2) reset = 1'b1;
      step();
    end
    wr_data_valid = 1'b0;
    reset = 1'b0;
    check_idle_outputs("mid_reset");
    exp_q.delete();
    wr_start_used = wr_start_cnt;
    $display("[TB] mid-block reset applied");
    step();
    start = 1'b1; step(); start = 1'b0;
    write_block(mk_blk(16), 1'b0);
    read_block(4, 1'b1);

    // Overflow: two extra beats must be dropped, not wrapped onto beat 0.
    b = mk_blk(20);
    b.nbeats = BEATS + 2;
    write_block(b, 1'b0);
    read_block(4, 1'b1);

`ifdef IMEM_RD_BOUNDS_CHECK_EN
    b = mk_blk(21);
    b.nbeats = 4;
    write_block(b, 1'b0);
    chk("oob_err_before", 64'(rd_oob_err), 0);
    wait_ready();
    do_read(7, inst_val(b, 7));
    do_read(9, 32'd0);
    chk("oob_err_after", 64'(rd_oob_err), 1);
    finish_read();
`endif

    // Randomized traffic against the queue model.
    tag = 100;
    for (int it = 0; it < 40; it++) begin
      if (exp_q.size() == 0 || (exp_q.size() < NB && $urandom_range(0, 1) == 1)) begin
        write_block(mk_blk(tag), 1'b0);
        tag++;
      end else begin
        read_block(int'($urandom_range(1, 5)), 1'b1);
      end
    end
    extra = exp_q.size();
    for (int j = 0; j < extra; j++) read_block(2, 1'b1);
    chk("final_num_full", 64'(num_full), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
